// File: rtl/sdr_port_arbiter.sv
// sdr_port_arbiter
//   Two-requester arbiter for the single toggle-handshake SDRAM port.
//   Port A (68000 bus, read/write) and port B (graphics ROM fetch, read-only)
//   compete for the downstream sdr_cpu_* channel. The arbiter holds one
//   request at a time, forwards it downstream and returns the read data and
//   the acknowledge toggle to whichever port owns the transfer.
//   PRIO_A = 1 gives port A fixed priority. PRIO_A = 0 alternates between
//   the ports when both are waiting.
//
// Ports
//   clk, reset_n             system clock, synchronous active-low reset
//   a_addr/a_data/a_be/a_rw  port A word address [26:1], write data,
//                            byte enables, direction (1 = read)
//   a_req -> a_ack, a_q      port A toggle handshake and read data
//   b_addr                   port B word address (reads only)
//   b_req -> b_ack, b_q      port B toggle handshake and read data
//   sdr_addr/data/be/rw      downstream command, held stable while busy
//   sdr_req -> sdr_ack,sdr_q downstream toggle handshake and read data
//   Every output comes straight from a register.

module sdr_port_arbiter #(
    parameter bit PRIO_A = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [25:0] a_addr,
    input  logic [15:0] a_data,
    input  logic [1:0]  a_be,
    input  logic        a_rw,
    input  logic        a_req,
    output logic        a_ack,
    output logic [15:0] a_q,

    input  logic [25:0] b_addr,
    input  logic        b_req,
    output logic        b_ack,
    output logic [15:0] b_q,

    output logic [25:0] sdr_addr,
    output logic [15:0] sdr_data,
    output logic [1:0]  sdr_be,
    output logic        sdr_rw,
    output logic        sdr_req,
    input  logic        sdr_ack,
    input  logic [15:0] sdr_q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_q;        // most recent grant: 0 = A, 1 = B
    logic        a_ack_q;
    logic        b_ack_q;
    logic [15:0] a_rdata_q;
    logic [15:0] b_rdata_q;
    logic [25:0] sdr_addr_q;
    logic [15:0] sdr_data_q;
    logic [1:0]  sdr_be_q;
    logic        sdr_rw_q;
    logic        sdr_req_q;

    logic a_pend;
    logic b_pend;
    logic sdr_done;
    logic grant_a;

    assign a_pend   = a_req ^ a_ack_q;
    assign b_pend   = b_req ^ b_ack_q;
    assign sdr_done = (sdr_ack == sdr_req_q);

    // A wins when it is alone, when it has fixed priority, or when B was
    // the most recent grant.
    assign grant_a  = a_pend && (!b_pend || PRIO_A || last_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            // Align every toggle pair so that no request is pending and an
            // abandoned downstream transfer never completes.
            sdr_req_q  <= sdr_ack;
            a_ack_q    <= a_req;
            b_ack_q    <= b_req;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            sdr_addr_q <= '0;
            sdr_data_q <= '0;
            sdr_be_q   <= '0;
            sdr_rw_q   <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_a) begin
                        sdr_addr_q <= a_addr;
                        sdr_data_q <= a_data;
                        sdr_be_q   <= a_be;
                        sdr_rw_q   <= a_rw;
                        sdr_req_q  <= ~sdr_req_q;
                        state_q    <= BUSY_A;
                    end else if (b_pend) begin
                        sdr_addr_q <= b_addr;
                        sdr_be_q   <= 2'b11;
                        sdr_rw_q   <= 1'b1;
                        sdr_req_q  <= ~sdr_req_q;
                        state_q    <= BUSY_B;
                    end
                end
                BUSY_A: begin
                    if (sdr_done) begin
                        a_rdata_q <= sdr_q;
                        a_ack_q   <= ~a_ack_q;
                        last_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                BUSY_B: begin
                    if (sdr_done) begin
                        b_rdata_q <= sdr_q;
                        b_ack_q   <= ~b_ack_q;
                        last_q    <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_ack    = a_ack_q;
    assign a_q      = a_rdata_q;
    assign b_ack    = b_ack_q;
    assign b_q      = b_rdata_q;
    assign sdr_addr = sdr_addr_q;
    assign sdr_data = sdr_data_q;
    assign sdr_be   = sdr_be_q;
    assign sdr_rw   = sdr_rw_q;
    assign sdr_req  = sdr_req_q;

endmodule

// File: doc/sdr_port_arbiter.md
# sdr_port_arbiter

Two-requester arbiter that shares the single toggle-handshake SDRAM port between the 68000 bus interface (port A, read/write) and a graphics ROM fetch client (port B, read-only, e.g. TC0100SCN tile fetch). It sits between the F2 top-level chip-select and request logic and the SDRAM controller's `sdr_cpu_*` channel. It latches one request at a time, forwards it downstream, and returns data and the acknowledge to the owning requester. Fairness is round-robin unless fixed CPU priority is selected.

## Interface
- `PRIO_A`, default 0: 1 means port A always wins simultaneous arbitration; 0 means round-robin.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `a_addr`  in  26  port A word address, bits [26:1].
- `a_data`  in  16  port A write data.
- `a_be`  in  2  port A byte enables, [1] upper, [0] lower.
- `a_rw`  in  1  port A direction: 1 read, 0 write.
- `a_req`  in  1  port A toggle request.
- `a_ack`  out  1  port A toggle acknowledge.
- `a_q`  out  16  port A read data.
- `b_addr`  in  26  port B word address.
- `b_req`  in  1  port B toggle request.
- `b_ack`  out  1  port B toggle acknowledge.
- `b_q`  out  16  port B read data.
- `sdr_addr`  out  26  downstream address.
- `sdr_data`  out  16  downstream write data.
- `sdr_be`  out  2  downstream byte enables.
- `sdr_rw`  out  1  downstream direction: 1 read, 0 write.
- `sdr_req`  out  1  downstream toggle request.
- `sdr_ack`  in  1  downstream toggle acknowledge.
- `sdr_q`  in  16  downstream read data.

## Operation
- Pending: a port is pending when `x_req != x_ack`. Downstream is busy when `sdr_req != sdr_ack`.
- States are IDLE, BUSY_A and BUSY_B. A `last` bit records the most recent grant (0 = A, 1 = B).
- IDLE with only A pending:
  - Latch `a_addr`, `a_data`, `a_be` and `a_rw` onto the `sdr_*` outputs.
  - Toggle `sdr_req` and go to BUSY_A.
- IDLE with only B pending:
  - Latch `b_addr` onto `sdr_addr`; set `sdr_rw`=1, `sdr_be`=2'b11, `sdr_data` unchanged.
  - Toggle `sdr_req` and go to BUSY_B.
- IDLE with both A and B pending:
  - If `PRIO_A`=1, A is granted.
  - Otherwise the port not equal to `last` is granted.
- BUSY_x, when `sdr_ack == sdr_req`:
  - `x_q` <= `sdr_q`. This happens on writes too; the value is don't-care.
  - Toggle `x_ack`, set `last` to x, return to IDLE.
- BUSY_x, while `sdr_ack != sdr_req`: hold. The `sdr_*` outputs are stable; new toggles on either `x_req` are not observed.
- Requesters must not toggle `x_req` again until they have seen `x_ack` match. A second toggle while pending is a protocol violation and is not detected.
- The non-owning port's `q` and `ack` never change during a grant.

## Timing
- Reset values, taken when `reset_n`=0 at a rising edge:
  - state IDLE, `last`=1 (A is favoured first).
  - `sdr_req` <= `sdr_ack`, `a_ack` <= `a_req`, `b_ack` <= `b_req`.
  - `a_q`=`b_q`=0, `sdr_addr`=0, `sdr_data`=0, `sdr_be`=0, `sdr_rw`=1.
  - Requests pending at reset are discarded. An outstanding downstream transfer is abandoned without a spurious completion.
- Grant latency: a request toggle visible in cycle n, with the block in IDLE, gives a `sdr_req` toggle and valid `sdr_*` at the edge ending cycle n. This is 1 clock.
- Completion latency: `sdr_ack` matching in cycle m gives `x_q` and the toggled `x_ack` at the edge ending cycle m. `x_q` is valid no later than `x_ack`.
- Turnaround: a new grant is possible in cycle m+1. Minimum spacing between `sdr_req` toggles is 2 clocks after the ack.
- If `sdr_ack` matches in the same cycle the other port toggles its request: completion is processed first. The other port is granted in the next IDLE cycle.
- Everything is registered. No combinational path from any input to any output.

## Test plan
- Single A read:
  - Stimulus: `a_addr`=26'h0000100, toggle `a_req`. Downstream returns `sdr_q`=16'hBEEF after 5 clk.
  - Required: `sdr_req` toggles 1 clk after the request with `sdr_rw`=1 and `sdr_addr`=26'h0000100; `a_q`=16'hBEEF and `a_ack` toggle 1 clk after `sdr_ack`; `b_ack` unchanged.
- A write:
  - Stimulus: `a_rw`=0, `a_be`=2'b01, `a_data`=16'h1234 at 26'h0080000.
  - Required: `sdr_be`=2'b01, `sdr_data`=16'h1234, `sdr_rw`=0; `a_ack` toggles after `sdr_ack`.
- Single B read:
  - Stimulus: `b_addr`=26'h0400000.
  - Required: `sdr_be`=2'b11, `sdr_rw`=1; `b_q` receives `sdr_q`.
- Simultaneous, `PRIO_A`=0, right after reset:
  - Stimulus: A and B toggle in the same cycle, repeated 4 rounds.
  - Required: grant order A,B,A,B… Each port gets its own data and is never served twice in a row while the other is pending.
- `PRIO_A`=1:
  - Stimulus: A re-requests immediately after each ack for 10 transfers while B is pending.
  - Required: B is not granted until A stops requesting, then granted once.
- Reset mid-transfer:
  - Stimulus: in BUSY_A with `sdr_req`=1 and `sdr_ack`=0, pulse `reset_n` low 1 clk while `sdr_ack` goes to 1.
  - Required: after reset, `sdr_req`=`sdr_ack`=1; no `a_ack` toggle; a subsequent A request completes normally.
